// File: rtl/spi_cfg_master.sv
// Two-requester SPI mode-0 register-write master: round-robin arbitration, 16-bit frames {1, addr, data}.
// Optional macro SPI_CFG_ADDR_CHECK_EN rejects requests with addr > 4 (err pulse, no frame).
module spi_cfg_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    input  logic       req1_valid,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SCLK_HI = 3'd2,
        SCLK_LO = 3'd3,
        GAP     = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t      state_r;
    logic [7:0]  div_r;
    logic [3:0]  bit_r;
    logic [14:0] shift_r;     // remaining frame bits below the one on COPI
    logic        prio_r;      // 1: req1 wins a tie
    logic        armed_r;     // keeps ready low until the first clock after reset
    logic        grant1_s;
    logic        accept_s;
    logic        reject_s;
    logic [6:0]  sel_addr_s;
    logic [7:0]  sel_data_s;

    // Round-robin grant, handshake and request selection
    always_comb begin
        grant1_s   = req1_valid && (!req0_valid || prio_r);
        req0_ready = armed_r && (state_r == IDLE) && req0_valid && !grant1_s;
        req1_ready = armed_r && (state_r == IDLE) && grant1_s;
        accept_s   = req0_ready || req1_ready;
        if (grant1_s) begin
            sel_addr_s = req1_addr;
            sel_data_s = req1_data;
        end else begin
            sel_addr_s = req0_addr;
            sel_data_s = req0_data;
        end
`ifdef SPI_CFG_ADDR_CHECK_EN
        reject_s = (sel_addr_s > 7'd4);
`else
        reject_s = 1'b0;
`endif
    end

    // Frame sequencer: all SPI lines and status outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            div_r   <= 8'd0;
            bit_r   <= 4'd0;
            shift_r <= 15'd0;
            prio_r  <= 1'b0;
            armed_r <= 1'b0;
            nCS     <= 1'b1;
            SCLK    <= 1'b0;
            COPI    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            armed_r <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        prio_r <= ~grant1_s;
                        if (reject_s) begin
                            err <= 1'b1;
                        end else begin
                            shift_r <= {sel_addr_s, sel_data_s};
                            COPI    <= 1'b1;
                            nCS     <= 1'b0;
                            SCLK    <= 1'b0;
                            busy    <= 1'b1;
                            div_r   <= 8'd0;
                            bit_r   <= 4'd0;
                            state_r <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (div_r == DIV_LAST) begin
                        div_r   <= 8'd0;
                        SCLK    <= 1'b1;
                        state_r <= SCLK_HI;
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end
                SCLK_HI: begin
                    if (div_r == DIV_LAST) begin
                        div_r   <= 8'd0;
                        SCLK    <= 1'b0;
                        state_r <= SCLK_LO;
                        // after the last rising edge COPI keeps bit 0 for the hold phase
                        if (bit_r != 4'd15) begin
                            COPI    <= shift_r[14];
                            shift_r <= {shift_r[13:0], 1'b0};
                        end
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end
                SCLK_LO: begin
                    if (div_r == DIV_LAST) begin
                        div_r <= 8'd0;
                        if (bit_r == 4'd15) begin
                            nCS     <= 1'b1;
                            done    <= 1'b1;
                            state_r <= GAP;
                        end else begin
                            bit_r   <= bit_r + 4'd1;
                            SCLK    <= 1'b1;
                            state_r <= SCLK_HI;
                        end
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end
                GAP: begin
                    if (div_r == GAP_LAST) begin
                        div_r   <= 8'd0;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    nCS     <= 1'b1;
                    SCLK    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Randomized self-checking bench for spi_cfg_master with a transaction-level reference model.
module tb_spi_cfg_master;

`ifdef SPI_CFG_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [6:0] req0_addr = 7'd0, req1_addr = 7'd0;
    logic [7:0] req0_data = 8'd0, req1_data = 8'd0;
    logic       req0_ready, req1_ready, nCS, SCLK, COPI, busy, done, err;

    spi_cfg_master dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .nCS(nCS), .SCLK(SCLK), .COPI(COPI), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    // reference model state
    logic [15:0] exp_q[$];
    int          acc_q[$];
    int          ord_q[$];
    int          last_srv = 1;
    int          err_exp = 0;
    logic [6:0]  a0[4], a1[4];
    logic [7:0]  d0[4], d1[4];

    // bus monitor results
    logic [15:0] got_q[$];
    int          nb_q[$], lc_q[$], gap_q[$];
    int          mon_nb = 0, done_cnt = 0, err_cnt = 0, done_miss = 0, hold_viol = 0;

    initial begin
        logic [15:0] sh;
        int lc, hc;
        bit pncs, psclk, pcopi, gap_ok;
        sh = 16'd0; lc = 0; hc = 0; pncs = 1'b1; psclk = 1'b0; pcopi = 1'b0; gap_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sh = 16'd0; mon_nb = 0; lc = 0; hc = 0; pncs = 1'b1; psclk = 1'b0; gap_ok = 1'b0;
                continue;
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (pncs && !nCS) begin
                if (gap_ok) gap_q.push_back(hc);
                sh = 16'd0; mon_nb = 0; lc = 0;
            end
            if (!nCS) begin
                lc++;
                if (!psclk && SCLK) begin
                    sh = {sh[14:0], COPI};
                    mon_nb++;
                end
                if (psclk && SCLK && (COPI !== pcopi)) hold_viol++;
            end else begin
                hc++;
            end
            if (!pncs && nCS) begin
                got_q.push_back(sh); nb_q.push_back(mon_nb); lc_q.push_back(lc);
                if (!done) done_miss++;
                hc = 1; gap_ok = 1'b1;
            end
            pncs = nCS; psclk = SCLK; pcopi = COPI;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete(); acc_q.delete(); ord_q.delete();
        got_q.delete(); nb_q.delete(); lc_q.delete(); gap_q.delete();
        last_srv = 1;
        rst_n = 1'b1;
    endtask

    // Plays both requesters (n0 / n1 writes, req1 starting dly1 cycles later) and models arbitration
    task automatic drive(input int n0, input int n1, input int dly1);
        int s0, s1, n, w, ew;
        bit started1, v_busy, v_both, v_arb;
        logic [6:0] ad;
        logic [7:0] dt;
        s0 = 0; s1 = 0; n = 0; v_busy = 0; v_both = 0; v_arb = 0;
        @(posedge clk); #1;
        if (n0 > 0) begin req0_valid = 1'b1; req0_addr = a0[0]; req0_data = d0[0]; end
        started1 = (n1 == 0);
        if (!started1 && dly1 == 0) begin
            req1_valid = 1'b1; req1_addr = a1[0]; req1_data = d1[0]; started1 = 1'b1;
        end
        while ((s0 < n0 || s1 < n1) && n < 20000) begin
            @(negedge clk); n++;
            if (busy && (req0_ready || req1_ready)) v_busy = 1'b1;
            if (req0_ready && req1_ready) v_both = 1'b1;
            w = -1;
            if (req0_valid && req0_ready) w = 0;
            else if (req1_valid && req1_ready) w = 1;
            if (w >= 0) begin
                ew = (req0_valid && req1_valid) ? (last_srv == 1 ? 0 : 1) : (req0_valid ? 0 : 1);
                if (w != ew) v_arb = 1'b1;
                last_srv = w;
                ad = (w == 1) ? req1_addr : req0_addr;
                dt = (w == 1) ? req1_data : req0_data;
                if (CHK && ad > 7'd4) err_exp++;
                else exp_q.push_back({1'b1, ad, dt});
                acc_q.push_back(cyc); ord_q.push_back(w);
            end
            @(posedge clk); #1;
            if (w == 0) begin
                s0++;
                if (s0 < n0) begin req0_addr = a0[s0]; req0_data = d0[s0]; end
                else begin req0_valid = 1'b0; req0_addr = 7'($urandom); req0_data = 8'($urandom); end
            end
            if (w == 1) begin
                s1++;
                if (s1 < n1) begin req1_addr = a1[s1]; req1_data = d1[s1]; end
                else begin req1_valid = 1'b0; req1_addr = 7'($urandom); req1_data = 8'($urandom); end
            end
            if (!started1 && n >= dly1) begin
                req1_valid = 1'b1; req1_addr = a1[0]; req1_data = d1[0]; started1 = 1'b1;
            end
        end
        n_checks++;
        if (n >= 20000) begin n_fail++; $display("FAIL drive_timeout: %0d of %0d/%0d of %0d accepted", s0, n0, s1, n1); end
        n_checks++;
        if (v_busy) begin n_fail++; $display("FAIL ready_while_busy: ready seen 1, required 0"); end
        n_checks++;
        if (v_both) begin n_fail++; $display("FAIL ready_both: both readies 1, required one"); end
        n_checks++;
        if (v_arb) begin n_fail++; $display("FAIL arbitration: granted requester differs from round-robin model"); end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((got_q.size() < exp_q.size() || busy) && n < 5000) begin
            @(negedge clk); n++;
        end
        #1;
        n_checks++;
        if (n >= 5000) begin n_fail++; $display("FAIL wait_idle: %0d frames seen, %0d expected", got_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #12;
        n_checks++;
        if ({nCS, SCLK, COPI, busy, done, err} !== 6'b100000) begin
            n_fail++; $display("FAIL reset_outputs: nCS,SCLK,COPI,busy,done,err=%b required 100000", {nCS, SCLK, COPI, busy, done, err});
        end
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: %b required 00", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single();
        int dn;
        logic [15:0] e, g;
        dn = done_cnt;
        a0[0] = 7'd4; d0[0] = 8'h80;
        drive(1, 0, 0);
        n_checks++;
        if ({nCS, SCLK, COPI, busy} !== 4'b0011) begin
            n_fail++; $display("FAIL single_start: nCS,SCLK,COPI,busy=%b required 0011", {nCS, SCLK, COPI, busy});
        end
        wait_idle();
        e = exp_q.pop_front();
        g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
        n_checks++;
        if (g !== 16'h8480 || e !== 16'h8480) begin n_fail++; $display("FAIL single_frame: got %h required 8480", g); end
        n_checks++;
        if (nb_q.size() == 0 || nb_q[0] !== 16 || lc_q[0] !== 132) begin
            n_fail++; $display("FAIL single_timing: bits/low cycles got %0d/%0d required 16/132",
                               (nb_q.size() > 0) ? nb_q[0] : -1, (lc_q.size() > 0) ? lc_q[0] : -1);
        end
        nb_q.delete(); lc_q.delete();
        n_checks++;
        if (done_cnt - dn !== 1) begin n_fail++; $display("FAIL single_done: %0d pulses required 1", done_cnt - dn); end
    endtask

    task automatic test_tie();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            a0[i] = 7'($urandom); d0[i] = 8'($urandom);
            if (CHK) a0[i] = 7'($urandom_range(0, 4));
        end
        a1[0] = CHK ? 7'($urandom_range(0, 4)) : 7'($urandom); d1[0] = 8'($urandom);
        drive(2, 1, 0);
        wait_idle();
        n_checks++;
        if (ord_q.size() != 3 || ord_q[0] != 0 || ord_q[1] != 1 || ord_q[2] != 0) begin
            n_fail++; $display("FAIL tie_order: got %p required '{0,1,0}", ord_q);
        end
        while (exp_q.size() > 0) begin
            logic [15:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL tie_frame: got %h required %h", g, e); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        a0[0] = 7'd1; d0[0] = 8'($urandom); a0[1] = 7'd3; d0[1] = 8'($urandom);
        drive(2, 0, 0);
        wait_idle();
        n_checks++;
        if (acc_q.size() != 2 || acc_q[1] - acc_q[0] != 137) begin
            n_fail++; $display("FAIL b2b_interval: got %0d cycles required 137", (acc_q.size() == 2) ? acc_q[1] - acc_q[0] : -1);
        end
        n_checks++;
        if (gap_q.size() != 1 || gap_q[0] < 4) begin
            n_fail++; $display("FAIL b2b_gap: nCS high %0d cycles required >= 4", (gap_q.size() > 0) ? gap_q[0] : -1);
        end
        while (exp_q.size() > 0) begin
            logic [15:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL b2b_frame: got %h required %h", g, e); end
        end
    endtask

    task automatic test_midframe_req();
        do_reset();
        a0[0] = 7'd2; d0[0] = 8'($urandom); a1[0] = 7'd0; d1[0] = 8'($urandom);
        drive(1, 1, 20 + int'($urandom_range(0, 80)));
        wait_idle();
        n_checks++;
        if (ord_q.size() != 2 || ord_q[0] != 0 || ord_q[1] != 1) begin
            n_fail++; $display("FAIL midframe_order: got %p required '{0,1}", ord_q);
        end
        while (exp_q.size() > 0) begin
            logic [15:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL midframe_frame: got %h required %h", g, e); end
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        do_reset();
        a0[0] = 7'd3; d0[0] = 8'($urandom);
        drive(1, 0, 0);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!(mon_nb == 8 && SCLK) && n < 1000);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({nCS, SCLK, busy} !== 3'b100 || n >= 1000) begin
            n_fail++; $display("FAIL abort_reset: nCS,SCLK,busy=%b required 100", {nCS, SCLK, busy});
        end
        exp_q.delete(); got_q.delete();
        @(negedge clk); rst_n = 1'b1; last_srv = 1;
        a0[0] = 7'($urandom_range(0, 4)); d0[0] = 8'($urandom);
        drive(1, 0, 0);
        wait_idle();
        n_checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL post_abort_frame: got %p required %p", got_q, exp_q);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_addr5();
        int ec;
        do_reset();
        ec = err_cnt;
        a0[0] = 7'd5; d0[0] = 8'($urandom);
        drive(1, 0, 0);
        if (CHK) begin
            n_checks++;
            if ({err, busy, nCS} !== 3'b101) begin
                n_fail++; $display("FAIL addr5_reject: err,busy,nCS=%b required 101", {err, busy, nCS});
            end
            repeat (10) @(negedge clk);
            n_checks++;
            if (err_cnt - ec !== 1 || got_q.size() != 0) begin
                n_fail++; $display("FAIL addr5_nofr: err pulses %0d frames %0d required 1/0", err_cnt - ec, got_q.size());
            end
        end else begin
            wait_idle();
            n_checks++;
            if (got_q.size() != 1 || got_q[0] !== {8'h85, d0[0]}) begin
                n_fail++; $display("FAIL addr5_frame: got %p required %h", got_q, {8'h85, d0[0]});
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        int n0, n1, ec;
        do_reset();
        ec = err_cnt;
        err_exp = 0;
        for (int it = 0; it < 5; it++) begin
            n0 = $urandom_range(0, 2);
            n1 = $urandom_range(1, 2);
            for (int i = 0; i < 4; i++) begin
                a0[i] = 7'($urandom); d0[i] = 8'($urandom);
                a1[i] = 7'($urandom); d1[i] = 8'($urandom);
            end
            drive(n0, n1, $urandom_range(0, 200));
            wait_idle();
            while (exp_q.size() > 0) begin
                logic [15:0] e, g;
                e = exp_q.pop_front();
                g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
                n_checks++;
                if (g !== e) begin n_fail++; $display("FAIL random_frame: got %h required %h", g, e); end
            end
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (err_cnt - ec !== err_exp || got_q.size() != 0) begin
            n_fail++; $display("FAIL random_err: err pulses %0d extra frames %0d required %0d/0", err_cnt - ec, got_q.size(), err_exp);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_midframe_req();
        test_reset_midframe();
        test_addr5();
        test_random();
        n_checks++;
        if (hold_viol !== 0 || done_miss !== 0) begin
            n_fail++; $display("FAIL bus_rules: COPI changes in SCLK high %0d, rises without done %0d, required 0/0", hold_viol, done_miss);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_cfg_master.md
SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal range 4..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 4: minimum clk cycles nCS stays high between frames; legal range 1..255.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  write request pending from requester 0 / 1.
REQ-006 SHALL have ports req0_addr / req1_addr  input  7  target register address.
REQ-007 SHALL have ports req0_data / req1_data  input  8  register write data.
REQ-008 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle when valid is also high.
REQ-009 SHALL have ports nCS, SCLK, COPI  output  1 each  SPI mode-0 controller lines, all driven from registers.
REQ-010 SHALL have port busy  output  1  high from the cycle after acceptance until return to IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse per completed frame.
REQ-012 SHALL have port err  output  1  one-cycle pulse per rejected request (only with SPI_CFG_ADDR_CHECK_EN).

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, SCLK_HI, SCLK_LO, GAP.
REQ-014 reqN_ready SHALL be high only in IDLE, for the granted requester, and only while that requester's valid is high; the handshake completes when valid and ready are both high in the same cycle (cycle T).
REQ-015 Arbitration SHALL be round-robin: a lone valid requester is granted; on a tie, the requester not served last is granted; after reset, req0 wins the first tie.
REQ-016 Requesters SHALL hold valid, addr and data stable until ready; addr and data SHALL be captured at cycle T.
REQ-017 The frame SHALL be 16 bits, MSB first: {1'b1, addr[6:0], data[7:0]}.
REQ-018 At T+1: nCS=0, SCLK=0, COPI=frame bit 15; state SETUP is held for CLK_DIV cycles.
REQ-019 SCLK_HI SHALL hold SCLK=1 for CLK_DIV cycles with COPI stable; SCLK_LO SHALL hold SCLK=0 for CLK_DIV cycles, with COPI updated to the next bit on entry to SCLK_LO.
REQ-020 After the 16th SCLK_HI, SCLK_LO SHALL act as the hold phase (COPI held at bit 0); nCS SHALL then rise at T+1+33*CLK_DIV.
REQ-021 done SHALL pulse in the cycle nCS rises; state GAP SHALL then hold nCS=1, SCLK=0 for GAP_CYCLES before IDLE.
REQ-022 With defaults, nCS SHALL be low for exactly 132 cycles and the earliest next acceptance SHALL be T+137.
REQ-023 valid rising while not in IDLE SHALL leave the request pending, with ready low, until IDLE; no request SHALL ever be dropped.
REQ-024 Bit and divider counters SHALL reset to 0 on each frame start; no wrap-around SHALL occur within a frame.

Reset
REQ-025 On rst_n low, asynchronously: nCS=1, SCLK=0, COPI=0, busy=0, done=0, err=0, ready=0, state=IDLE, round-robin pointer = req0.
REQ-026 Reset mid-frame SHALL abort the frame immediately (nCS high); the partial frame SHALL NOT be resent after reset.

Configuration
REQ-027 With macro SPI_CFG_ADDR_CHECK_EN defined, a request with addr > 7'd4 SHALL be accepted normally (ready, arbitration pointer updated) but SHALL NOT produce a frame: err pulses at T+1, busy and nCS stay idle, and IDLE is kept.
REQ-028 Without SPI_CFG_ADDR_CHECK_EN, every address SHALL be transmitted, and err SHALL be tied to 0.

Verification
REQ-029 req0 addr=4 data=0x80 -> COPI sampled on 16 SCLK rises = 0x8480; nCS low 132 cycles; one done pulse.
REQ-030 req0 and req1 both valid after reset -> req0 frame, then req1 frame; a repeated tie then serves req1 first.
REQ-031 Back-to-back req0 writes -> nCS high for >= GAP_CYCLES (4) between frames; both frames correct.
REQ-032 rst_n low during the 8th SCLK_HI -> nCS=1, SCLK=0 with no clk edge; next request sends a complete 0x8xxx frame.
REQ-033 addr=5 with SPI_CFG_ADDR_CHECK_EN -> ready for 1 cycle, err pulse, no nCS activity; without the macro -> frame 0x85xx is sent.
REQ-034 req1_valid raised mid-frame -> req1_ready stays low until IDLE, then its frame is sent unchanged.
